sm83_timer: RTL and testbench
=============================

# sm83_timer

Memory-mapped DIV/TIMA/TMA/TAC timer peripheral on the `sm83_core` data bus, decoding `0xFF04`–`0xFF07`. The top-level read mux and write strobe feed it the same way they feed the ROM0 and WRAM0 regions. It keeps a free-running 16-bit divider, a programmable 8-bit counter with modulo reload, and a one-cycle timer interrupt request toward the interrupt logic.

## Interface
- `OVF_DELAY`, default 4: clocks TIMA reads `0x00` after overflow before the TMA reload; legal range 1–15.
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst_n`  in  1: reset. Synchronous, active-low: sampled on the rising edge of `clk`, and all state clears when it is low.
- `addr`  in  16 (`addr_t`): shared CPU address; reads and writes use the same bus.
- `w_data`  in  8 (`data_t`): CPU write data.
- `w_wen`  in  1: CPU write strobe.
- `r_data`  out  8 (`data_t`): register read data. Combinational; `0x00` when `r_hit`=0.
- `r_hit`  out  1: `addr` is in `0xFF04`–`0xFF07`. The top-level mux uses it to select `r_data`.
- `irq`  out  1: timer interrupt request; one-clock pulse.

## Operation
- Registers:
  - DIV (`0xFF04`): reads `cnt[15:8]`. A write of any value clears `cnt` to `0x0000`.
  - TIMA (`0xFF05`): read/write counter.
  - TMA (`0xFF06`): read/write reload value.
  - TAC (`0xFF07`): only bits `[2:0]` are stored; reads return `{5'b11111, tac[2:0]}`.
- `cnt` increments by 1 every clock and wraps `0xFFFF`→`0x0000`.
- Tap selection by `tac[1:0]`: `00`→`cnt[9]`, `01`→`cnt[3]`, `10`→`cnt[5]`, `11`→`cnt[7]`.
- Timer signal and increment:
  - `tsig = tac[2] & tap`; `tsig_q` is registered every clock.
  - A TIMA increment event occurs when `tsig_q`=1 and `tsig`=0 (falling edge). TIMA is updated on the same edge.
- Overflow state machine, states `RUN`, `OVF`, `RELOAD`:
  - `RUN`: an increment event with TIMA=`0xFF` sets TIMA←`0x00`, sets the delay counter←`OVF_DELAY-1`, and moves to `OVF`.
  - `OVF`: TIMA holds `0x00` and increment events are ignored. The delay counter decrements each clock; at 0 the state moves to `RELOAD`. A CPU write to TIMA while in `OVF` stores the write data, cancels both reload and `irq`, and returns to `RUN`.
  - `RELOAD`: one clock. TIMA←TMA, where TMA is the value written this same cycle if a TMA write is present. `irq`=1 for this cycle only. A TIMA write in this cycle is ignored. Next state is `RUN`.
- Priority in `RUN`: a CPU write to TIMA overrides a simultaneous increment event.
- Simultaneous DIV write and falling tap: treated per the Configuration section.

## Timing
- Reset values: `cnt`=0, TIMA=0, TMA=0, `tac`=0 (reads `0xF8`), `tsig_q`=0, state=`RUN`, `irq`=0. `r_data` and `r_hit` follow `addr` combinationally.
- Reset mid-overflow discards the pending reload and emits no `irq`.
- A write lands at the rising edge where `w_wen`=1 and `addr` matches. Reads return the post-write value starting the next cycle.
- Increment latency: an edge falling in `cnt` at clock N shows as TIMA+1 after edge N+1.
- TAC=`0x05` gives a TIMA period of 16 clocks; `0x04` gives 1024.
- Overflow-to-reload: `OVF_DELAY` clocks reading `0x00`, then one `RELOAD` clock in which `irq` is high.

## Configuration
- `SM83_TIMER_DIV_GLITCH_EN` defined: a falling `tsig` caused by a DIV write or a TAC write counts as an increment event, for hardware-accurate glitches.
- Not defined: `tsig_q` is forced to the new `tsig` on the cycle after any DIV or TAC write, so such writes never increment TIMA.

## Test plan
- Reset: hold `rst_n`=0 for 2 clocks → reads of `0xFF04`–`0xFF07` return `00`,`00`,`00`,`F8`; `irq`=0; `r_hit`=0 at `0xC000`.
- DIV: after reset, run 256 clocks → DIV reads `0x01`. Write `0xAB` to `0xFF04` → DIV reads `0x00` and `cnt` restarts from 0.
- Count rate: write TAC=`0x05`, DIV=0, run 160 clocks → TIMA=`0x0A`. Switch to TAC=`0x04` → TIMA advances by 1 per 1024 clocks.
- Overflow: TMA=`0x80`, TIMA=`0xFF`, TAC=`0x05` → TIMA reads `0x00` for 4 clocks, then `0x80`; `irq` is high exactly 1 clock, coincident with the reload.
- Cancel: during the `0x00` window write TIMA=`0x33` → TIMA=`0x33` and no `irq`. A write to TIMA in the `RELOAD` cycle is ignored, and TIMA=TMA.
- Glitch: TAC=`0x05`, wait until `cnt[3]`=1, then write DIV → TIMA increments by 1 with the macro defined and is unchanged without it.

Source files
------------

// File: rtl/sm83_timer.sv
// DIV/TIMA/TMA/TAC timer at 0xFF04-0xFF07 with overflow delay, TMA reload and a one-clock irq.
// Optional macro SM83_TIMER_DIV_GLITCH_EN: DIV/TAC writes that drop the timer signal count as increments.
module sm83_timer #(
  parameter int OVF_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  w_data,
  input  logic        w_wen,
  output logic [7:0]  r_data,
  output logic        r_hit,
  output logic        irq
);

  localparam int DATA_W = 8;
  localparam logic [3:0] DLY_INIT = 4'(OVF_DELAY - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } state_t;

  state_t              state;
  logic [15:0]         cnt;
  logic [DATA_W-1:0]   tima;
  logic [DATA_W-1:0]   tma;
  logic [2:0]          tac;
  logic [3:0]          dly;
  logic                tsig_q;
  logic                tap;
  logic                tsig;
  logic                inc_evt;
  logic                wr_hit;
  logic                wr_div;
  logic                wr_tima;
  logic                wr_tma;
  logic                wr_tac;

  assign r_hit   = (addr[15:2] == 14'h3FC1);
  assign wr_hit  = w_wen & r_hit;
  assign wr_div  = wr_hit & (addr[1:0] == 2'd0);
  assign wr_tima = wr_hit & (addr[1:0] == 2'd1);
  assign wr_tma  = wr_hit & (addr[1:0] == 2'd2);
  assign wr_tac  = wr_hit & (addr[1:0] == 2'd3);

  always_comb begin
    r_data = '0;
    if (r_hit) begin
      case (addr[1:0])
        2'd0:    r_data = cnt[15:8];
        2'd1:    r_data = tima;
        2'd2:    r_data = tma;
        default: r_data = {5'b11111, tac};
      endcase
    end
  end

  always_comb begin
    case (tac[1:0])
      2'b00:   tap = cnt[9];
      2'b01:   tap = cnt[3];
      2'b10:   tap = cnt[5];
      default: tap = cnt[7];
    endcase
  end

  assign tsig = tac[2] & tap;

`ifdef SM83_TIMER_DIV_GLITCH_EN
  assign inc_evt = tsig_q & ~tsig;
`else
  // A DIV/TAC write flags the next cycle so its forced drop in tsig is not seen as an edge.
  logic wr_sup_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sup_q <= 1'b0;
    end else begin
      wr_sup_q <= wr_div | wr_tac;
    end
  end

  assign inc_evt = tsig_q & ~tsig & ~wr_sup_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      tima   <= '0;
      tma    <= '0;
      tac    <= '0;
      dly    <= '0;
      tsig_q <= 1'b0;
      irq    <= 1'b0;
      state  <= RUN;
    end else begin
      cnt    <= wr_div ? 16'h0000 : cnt + 16'd1;
      tsig_q <= tsig;
      irq    <= 1'b0;
      if (wr_tma) tma <= w_data;
      if (wr_tac) tac <= w_data[2:0];

      case (state)
        RUN: begin
          if (wr_tima) begin
            tima <= w_data;
          end else if (inc_evt) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              dly   <= DLY_INIT;
              state <= OVF;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        OVF: begin
          if (wr_tima) begin
            tima  <= w_data;
            state <= RUN;
          end else if (dly == 4'd0) begin
            // Reload lands on entry so the RELOAD clock already reads TMA alongside irq.
            tima  <= wr_tma ? w_data : tma;
            irq   <= 1'b1;
            state <= RELOAD;
          end else begin
            dly <= dly - 4'd1;
          end
        end
        RELOAD: begin
          if (wr_tma) tima <= w_data;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_timer.sv
// Scoreboard bench for sm83_timer: the driver queues expected read results, a negedge monitor compares them.
module tb_sm83_timer;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  w_data;
  logic        w_wen;
  logic [7:0]  r_data;
  logic        r_hit;
  logic        irq;
  logic        rd_req;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       hit;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

`ifdef SM83_TIMER_DIV_GLITCH_EN
  localparam logic [7:0] GLITCH_TIMA = 8'h11;
`else
  localparam logic [7:0] GLITCH_TIMA = 8'h10;
`endif

  sm83_timer #(.OVF_DELAY(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .w_data (w_data),
    .w_wen  (w_wen),
    .r_data (r_data),
    .r_hit  (r_hit),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (rd_req) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: read presented with no expected entry queued");
      end else begin
        mon_e = sb_q.pop_front();
        if (r_data !== mon_e.data || r_hit !== mon_e.hit || irq !== mon_e.irq) begin
          errors++;
          $display("FAIL %s: got r_data=%h r_hit=%b irq=%b, expected r_data=%h r_hit=%b irq=%b",
                   mon_e.name, r_data, r_hit, irq, mon_e.data, mon_e.hit, mon_e.irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d, input logic iq, input string nm);
    exp_t e;
    e.name = nm;
    e.data = d;
    e.hit  = (a >= 16'hFF04) && (a <= 16'hFF07);
    e.irq  = iq;
    sb_q.push_back(e);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic iq, input string nm);
    addr   = a;
    rd_req = 1'b1;
    push_exp(a, d, iq, nm);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr   = a;
    w_data = d;
    w_wen  = 1'b1;
    tick();
    w_wen  = 1'b0;
  endtask

  task automatic wr_rd(input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp_d,
                       input logic iq, input string nm);
    addr   = a;
    w_data = d;
    w_wen  = 1'b1;
    rd_req = 1'b1;
    push_exp(a, exp_d, iq, nm);
    tick();
    w_wen  = 1'b0;
    rd_req = 1'b0;
  endtask

  // Clear TAC, preload TIMA, restart DIV, then enable TAC=0x05; returns one clock after the TAC write.
  task automatic arm_fast(input logic [7:0] tima_v);
    wr(16'hFF07, 8'h00);
    wr(16'hFF05, tima_v);
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
  endtask

  initial begin
    rst_n  = 1'b0;
    addr   = 16'h0000;
    w_data = 8'h00;
    w_wen  = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    rd(16'hFF04, 8'h00, 1'b0, "rst_div");
    rd(16'hFF05, 8'h00, 1'b0, "rst_tima");
    rd(16'hFF06, 8'h00, 1'b0, "rst_tma");
    rd(16'hFF07, 8'hF8, 1'b0, "rst_tac");
    rd(16'hC000, 8'h00, 1'b0, "miss_c000");

    // DIV clear and rollover into the upper byte
    wr(16'hFF04, 8'hAB);
    rd(16'hFF04, 8'h00, 1'b0, "div_clr");
    repeat (254) tick();
    rd(16'hFF04, 8'h00, 1'b0, "div_255");
    rd(16'hFF04, 8'h01, 1'b0, "div_256");

    // TAC=0x05: one increment per 16 clocks
    wr(16'hFF05, 8'h00);
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
    repeat (15) tick();
    rd(16'hFF05, 8'h00, 1'b0, "rate16_pre");
    rd(16'hFF05, 8'h01, 1'b0, "rate16_first");
    repeat (142) tick();
    rd(16'hFF05, 8'h09, 1'b0, "rate16_9");
    rd(16'hFF05, 8'h0A, 1'b0, "rate16_10");

    // TAC=0x04: one increment per 1024 clocks
    wr(16'hFF07, 8'h04);
    repeat (861) tick();
    rd(16'hFF05, 8'h0A, 1'b0, "rate1k_pre");
    rd(16'hFF05, 8'h0B, 1'b0, "rate1k_first");
    repeat (1022) tick();
    rd(16'hFF05, 8'h0B, 1'b0, "rate1k_pre2");
    rd(16'hFF05, 8'h0C, 1'b0, "rate1k_second");
    rd(16'hFF07, 8'hFC, 1'b0, "tac_read");

    // overflow: four clocks of 0x00, then reload with irq
    wr(16'hFF07, 8'h00);
    wr(16'hFF06, 8'h80);
    arm_fast(8'hFF);
    repeat (15) tick();
    rd(16'hFF05, 8'hFF, 1'b0, "ovf_ff");
    for (int i = 0; i < 4; i++) rd(16'hFF05, 8'h00, 1'b0, "ovf_zero");
    rd(16'hFF05, 8'h80, 1'b1, "ovf_reload");
    rd(16'hFF05, 8'h80, 1'b0, "ovf_after");
    rd(16'hFF06, 8'h80, 1'b0, "ovf_tma");

    // TIMA write inside the zero window cancels reload and irq
    arm_fast(8'hFF);
    repeat (15) tick();
    rd(16'hFF05, 8'hFF, 1'b0, "cancel_ff");
    rd(16'hFF05, 8'h00, 1'b0, "cancel_zero0");
    rd(16'hFF05, 8'h00, 1'b0, "cancel_zero1");
    wr(16'hFF05, 8'h33);
    for (int i = 0; i < 3; i++) rd(16'hFF05, 8'h33, 1'b0, "cancel_hold");

    // TMA written on the reload edge is used; TIMA write in RELOAD is dropped
    arm_fast(8'hFF);
    repeat (15) tick();
    rd(16'hFF05, 8'hFF, 1'b0, "rl_ff");
    for (int i = 0; i < 3; i++) rd(16'hFF05, 8'h00, 1'b0, "rl_zero");
    wr_rd(16'hFF06, 8'h90, 8'h80, 1'b0, "rl_tma_old");
    wr_rd(16'hFF05, 8'h55, 8'h90, 1'b1, "rl_reload_new_tma");
    rd(16'hFF05, 8'h90, 1'b0, "rl_tima_ignored");
    rd(16'hFF06, 8'h90, 1'b0, "rl_tma_new");

    // DIV write while the tap is high
    arm_fast(8'h10);
    repeat (7) tick();
    wr(16'hFF04, 8'h00);
    rd(16'hFF05, 8'h10, 1'b0, "glitch_pre");
    rd(16'hFF05, GLITCH_TIMA, 1'b0, "glitch_post");
    rd(16'hFF05, GLITCH_TIMA, 1'b0, "glitch_hold");

    // reset inside the zero window drops the pending reload
    arm_fast(8'hFF);
    repeat (15) tick();
    rd(16'hFF05, 8'hFF, 1'b0, "rstovf_ff");
    rd(16'hFF05, 8'h00, 1'b0, "rstovf_zero");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd(16'hFF05, 8'h00, 1'b0, "rstovf_noirq");
    rd(16'hFF07, 8'hF8, 1'b0, "rstovf_tac");
    rd(16'hFF06, 8'h00, 1'b0, "rstovf_tma");

    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
